// File: rtl/vec_1_detector_core.sv
// Leading-one detector for a 32-bit vector: 1-based position of the first set bit from bit 31.
// Define VEC1_DET_PIPE_EN to register the group flags/offsets between tree levels (latency 2 instead of 1).
module vec_1_detector_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        vld_in,
    output logic [5:0]  pos_out,
    output logic        vld_out
);

    // Level 1: per-byte nonzero flag and leading-one offset (0 = byte MSB); group 0 is bits 31:24.
    logic [3:0]       grp_nz_next;
    logic [3:0][2:0]  grp_off_next;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_grp
            logic [7:0] grp_bits;
            logic [2:0] grp_off;

            assign grp_bits = data_in[31-8*gi -: 8];
            assign grp_nz_next[gi] = |grp_bits;

            // Scan upward so the highest set bit is the last assignment to stick.
            always_comb begin
                grp_off = 3'd0;
                for (int b = 0; b < 8; b++) begin
                    if (grp_bits[b]) begin
                        grp_off = 3'(7 - b);
                    end
                end
            end

            assign grp_off_next[gi] = grp_off;
        end
    endgenerate

    logic [3:0]       grp_nz_sel;
    logic [3:0][2:0]  grp_off_sel;
    logic             vld_sel;

`ifdef VEC1_DET_PIPE_EN
    logic [3:0]       grp_nz_reg;
    logic [3:0][2:0]  grp_off_reg;
    logic             vld_pipe_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_nz_reg   <= '0;
            grp_off_reg  <= '0;
            vld_pipe_reg <= 1'b0;
        end else begin
            grp_nz_reg   <= grp_nz_next;
            grp_off_reg  <= grp_off_next;
            vld_pipe_reg <= vld_in;
        end
    end

    assign grp_nz_sel  = grp_nz_reg;
    assign grp_off_sel = grp_off_reg;
    assign vld_sel     = vld_pipe_reg;
`else
    assign grp_nz_sel  = grp_nz_next;
    assign grp_off_sel = grp_off_next;
    assign vld_sel     = vld_in;
`endif

    // Level 2: highest nonzero group wins; position = group*8 + offset + 1.
    logic [5:0] pos_next;

    always_comb begin
        pos_next = 6'd0;
        for (int g = 3; g >= 0; g--) begin
            if (grp_nz_sel[g]) begin
                pos_next = {1'b0, 2'(g), grp_off_sel[g]} + 6'd1;
            end
        end
    end

    logic [5:0] pos_reg;
    logic       vld_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg <= 6'd0;
            vld_reg <= 1'b0;
        end else begin
            pos_reg <= pos_next;
            vld_reg <= vld_sel;
        end
    end

    assign pos_out = pos_reg;
    assign vld_out = vld_reg;

endmodule

// File: tb/tb_vec_1_detector_core.sv
// Self-checking bench for vec_1_detector_core: directed vectors, walking one, random vectors, mid-stream reset.
module tb_vec_1_detector_core;

`ifdef VEC1_DET_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        vld_in;
    logic [5:0]  pos_out;
    logic        vld_out;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_pos_q[$];
    logic       exp_vld_q[$];

    vec_1_detector_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .vld_in  (vld_in),
        .pos_out (pos_out),
        .vld_out (vld_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index of the most significant set bit k gives 32 - k; zero gives 0.
    function automatic logic [5:0] ref_pos(input logic [31:0] d);
        for (int k = 31; k >= 0; k--) begin
            if (d[k]) return 6'(32 - k);
        end
        return 6'd0;
    endfunction

    task automatic check_out(input string tag, input logic [5:0] p, input logic v);
        checks++;
        assert (pos_out === p) else begin
            errors++;
            $error("FAIL %s pos_out got %0d expected %0d", tag, pos_out, p);
        end
        checks++;
        assert (vld_out === v) else begin
            errors++;
            $error("FAIL %s vld_out got %0b expected %0b", tag, vld_out, v);
        end
    endtask

    task automatic prefill();
        exp_pos_q.delete();
        exp_vld_q.delete();
        for (int i = 0; i < LAT - 1; i++) begin
            exp_pos_q.push_back(6'd0);
            exp_vld_q.push_back(1'b0);
        end
    endtask

    // Apply one input for one cycle, then check the output due after this edge.
    task automatic step(input string tag, input logic [31:0] d, input logic v, input logic [5:0] p);
        logic [5:0] ep;
        logic       ev;
        data_in = d;
        vld_in  = v;
        exp_pos_q.push_back(p);
        exp_vld_q.push_back(v);
        @(posedge clk);
        #1;
        ep = exp_pos_q.pop_front();
        ev = exp_vld_q.pop_front();
        check_out(tag, ep, ev);
        $display("step %-8s data=%08h vld=%0b -> pos=%0d vld_out=%0b (exp %0d/%0b)",
                 tag, d, v, pos_out, vld_out, ep, ev);
    endtask

    initial begin
        logic [31:0] d;
        logic        v;

        rst_n   = 1'b0;
        data_in = 32'h0;
        vld_in  = 1'b0;
        #1;
        check_out("reset", 6'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prefill();

        // Directed vectors with hand-computed positions, back-to-back.
        step("dir18800", 32'h1880_0000, 1'b1, 6'd4);
        step("dir00FF", 32'h00FF_0000, 1'b1, 6'd9);
        step("dir000A", 32'h0000_000A, 1'b1, 6'd29);
        step("dirzero", 32'h0000_0000, 1'b1, 6'd0);
        step("dirmsb", 32'h8000_0000, 1'b1, 6'd1);
        step("dirlsb", 32'h0000_0001, 1'b1, 6'd32);
        step("dirall", 32'hFFFF_FFFF, 1'b0, 6'd1);
        step("dirnovld", 32'h0000_0100, 1'b0, 6'd24);
        step("dirbyte1", 32'h0001_0000, 1'b1, 6'd16);

        // Walking one, then walking one with random noise below it.
        for (int i = 0; i < 32; i++) begin
            d = 32'h1 << i;
            step("walk", d, 1'b1, ref_pos(d));
        end
        for (int i = 0; i < 32; i++) begin
            d = (32'h1 << i) | ($urandom & ((32'h1 << i) - 32'h1));
            step("walknz", d, 1'($urandom_range(0, 1)), ref_pos(d));
        end

        // Random vectors with varied leading-zero counts.
        for (int i = 0; i < 1000; i++) begin
            d = $urandom >> $urandom_range(0, 32);
            v = 1'($urandom_range(0, 1));
            step("rand", d, v, ref_pos(d));
        end

        // Mid-stream reset: outputs clear at once and in-flight results are dropped.
        step("prerst", 32'h0400_0000, 1'b1, 6'd6);
        step("prerst", 32'h0000_8000, 1'b1, 6'd17);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rstasync", 6'd0, 1'b0);
        data_in = 32'h0010_0000;
        vld_in  = 1'b1;
        @(posedge clk);
        #1;
        check_out("rsthold", 6'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        prefill();
        for (int i = 0; i < LAT + 1; i++) begin
            d = $urandom;
            step("postrst", d, 1'b0, ref_pos(d));
        end
        step("firstvld", 32'h0000_0040, 1'b1, 6'd26);
        step("tail", 32'h0000_0000, 1'b0, 6'd0);
        for (int i = 0; i < LAT; i++) begin
            step("drain", 32'h0200_0000, 1'b0, 6'd7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
